cnt_bank_seq: RTL



---
 rtl/cnt_bank_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/cnt_bank_seq.sv
// Sequencer for a bank of enable-gated terminal-count counters: runs the masked
// counters in parallel or one at a time, with clear gaps, timeout and abort.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; results of the last run held
// S_CLEAR   | cen low for CLR_CYC cycles so the bank clears before running
// S_RUN_PAR | all masked counters enabled, collecting tc flags
// S_RUN_SEQ | counter cur_idx enabled alone until its tc
// S_GAP     | cen low for CLR_CYC cycles between sequential counters
// S_FINISH  | one-cycle done pulse, cen low
module cnt_bank_seq #(
   parameter int NUM_CNT = 32,
   parameter int IDX_W   = 5,
   parameter int TO_W    = 20,
   parameter int CLR_CYC = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic               mode,
   input  logic [NUM_CNT-1:0] mask,
   input  logic [TO_W-1:0]    timeout,
   input  logic [NUM_CNT-1:0] tc,
   output logic [NUM_CNT-1:0] cen,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [NUM_CNT-1:0] done_mask,
   output logic [IDX_W-1:0]   cur_idx
);

   localparam int CLR_W = $clog2(CLR_CYC) + 1;
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_RUN_PAR, S_RUN_SEQ, S_GAP, S_FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [NUM_CNT-1:0] cen_q, cen_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [NUM_CNT-1:0] done_mask_q, done_mask_d;
   logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
   logic [NUM_CNT-1:0] mask_l;
   logic               mode_l;
   logic [TO_W-1:0]    to_l;
   logic               lat;
   logic [NUM_CNT-1:0] pending;
   logic [NUM_CNT-1:0] par_dm;
   logic [IDX_W-1:0]   next_idx;
   logic               to_hit;
   logic [TO_W-1:0]    to_inc;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CNT-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_CNT - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = IDX_W'(i);
      end
   endfunction

   assign pending  = mask_l & ~done_mask_q;
   assign next_idx = lowest_idx(pending);
   assign par_dm   = done_mask_q | (tc & mask_l);
   assign to_hit   = (to_l != '0) && (to_cnt_q == to_l - TO_W'(1));
   // Saturate so an unlimited run never wraps back through a small count.
   assign to_inc   = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_W'(1);

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      to_cnt_d    = to_cnt_q;
      cen_d       = '0;
      err_d       = err_q;
      done_mask_d = done_mask_q;
      cur_idx_d   = cur_idx_q;
      lat         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lat         = 1'b1;
               done_mask_d = '0;
               err_d       = 1'b0;
               cur_idx_d   = '0;
               clr_cnt_d   = CLR_LOAD;
               state_d     = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else if (mask_l == '0) begin
               state_d = S_FINISH;
            end else if (clr_cnt_q == '0) begin
               to_cnt_d = '0;
               if (mode_l) begin
                  state_d   = S_RUN_SEQ;
                  cur_idx_d = next_idx;
                  cen_d     = NUM_CNT'(1) << next_idx;
               end else begin
                  state_d = S_RUN_PAR;
                  cen_d   = mask_l;
               end
            end else begin
               clr_cnt_d = clr_cnt_q - CLR_W'(1);
            end
         end
         S_RUN_PAR: begin
            done_mask_d = par_dm;
            to_cnt_d    = to_inc;
            cen_d       = mask_l;
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
               cen_d   = '0;
            end else if (par_dm == mask_l) begin
               state_d = S_FINISH;
               cen_d   = '0;
            end else if (to_hit) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
               cen_d   = '0;
            end
         end
         S_RUN_SEQ: begin
            to_cnt_d = to_inc;
            cen_d    = NUM_CNT'(1) << cur_idx_q;
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
               cen_d   = '0;
            end else if (tc[cur_idx_q]) begin
               done_mask_d[cur_idx_q] = 1'b1;
               clr_cnt_d = CLR_LOAD;
               state_d   = S_GAP;
               cen_d     = '0;
            end else if (to_hit) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
               cen_d   = '0;
            end
         end
         S_GAP: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else if (clr_cnt_q == '0) begin
               if (pending == '0) begin
                  state_d = S_FINISH;
               end else begin
                  to_cnt_d  = '0;
                  state_d   = S_RUN_SEQ;
                  cur_idx_d = next_idx;
                  cen_d     = NUM_CNT'(1) << next_idx;
               end
            end else begin
               clr_cnt_d = clr_cnt_q - CLR_W'(1);
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         clr_cnt_q   <= '0;
         to_cnt_q    <= '0;
         cen_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         done_mask_q <= '0;
         cur_idx_q   <= '0;
         mask_l      <= '0;
         mode_l      <= 1'b0;
         to_l        <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         to_cnt_q    <= to_cnt_d;
         cen_q       <= cen_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         done_mask_q <= done_mask_d;
         cur_idx_q   <= cur_idx_d;
         if (lat) begin
            mask_l <= mask;
            mode_l <= mode;
            to_l   <= timeout;
         end
      end
   end

   assign cen       = cen_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign done_mask = done_mask_q;
   assign cur_idx   = cur_idx_q;

endmodule
